// File: rtl/event_fifo_reader_if.sv
// event_fifo_reader_if: framed 16-bit event stream with valid/ready handshake
interface event_fifo_reader_if;
  logic [15:0] data;
  logic valid;
  logic ready;
  logic start;
  logic last;
  modport master(output data, valid, start, last, input ready);
  modport slave(input data, valid, start, last, output ready);
endinterface

// File: rtl/event_fifo_reader.sv
// event_fifo_reader: drains the trigger event FIFO into a framed, length-bounded 16-bit stream
module event_fifo_reader #(
  parameter int g_max_event_words = 4096,
  parameter int g_count_width = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     fifo_empty,
  input  logic [17:0]              fifo_q,
  output logic                     fifo_re,
  event_fifo_reader_if.master      out,
  output logic [g_count_width-1:0] event_count,
  output logic                     err_framing,
  output logic                     err_overlength,
  output logic                     busy
);
  localparam int WW = $clog2(g_max_event_words + 1);
  typedef enum logic {IDLE, IN_EVENT} state_t;
  state_t state, state_n;
  logic [17:0] buf0, buf1, head, q0;
  logic [1:0] cnt, cnt_p, tag;
  logic in_flight, ld, pop, push, emit, start, last, ovl, ef;
  logic [WW-1:0] wc, wc_n;
  // Head word comes from the skid buffer, or straight from the FIFO when the buffer is empty
  always_comb begin
    head = cnt != 2'd0 ? buf0 : fifo_q;
    ld = (cnt != 2'd0 || in_flight) && (!out.valid || out.ready);
    pop = ld && cnt != 2'd0;
    push = in_flight && !(ld && cnt == 2'd0);
    cnt_p = cnt - {1'b0, pop};
    q0 = pop ? buf1 : buf0;
    fifo_re = reset_n & enable & ~fifo_empty & ((cnt + {1'b0, in_flight}) < 2'd2);
    busy = state == IN_EVENT || cnt != 2'd0 || in_flight || out.valid;
  end
  // Framing decision for the head word; tag[0] marks a start, tag[1] a last
  always_comb begin
    tag = head[17:16];
    ovl = state == IN_EVENT && tag == 2'b00 && wc == WW'(g_max_event_words - 1);
    emit = state == IN_EVENT || tag[0];
    start = tag[0];
    last = tag[1] | ovl;
    ef = state == IDLE ? !tag[0] : tag[0];
    state_n = last ? IDLE : (tag == 2'b01 ? IN_EVENT : state);
    wc_n = tag == 2'b01 ? WW'(1) : wc + WW'(1);
  end
  // Fetch tracking, skid buffer, output register, framing state and event counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      wc <= '0;
      in_flight <= 1'b0;
      cnt <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
      out.valid <= 1'b0;
      out.data <= '0;
      out.start <= 1'b0;
      out.last <= 1'b0;
      event_count <= '0;
      err_framing <= 1'b0;
      err_overlength <= 1'b0;
    end else begin
      in_flight <= fifo_re;
      cnt <= cnt_p + {1'b0, push};
      buf0 <= (push && cnt_p == 2'd0) ? fifo_q : q0;
      buf1 <= (push && cnt_p == 2'd1) ? fifo_q : buf1;
      err_framing <= ld && ef;
      err_overlength <= ld && ovl;
      if (out.valid && out.ready && out.last) event_count <= event_count + g_count_width'(1);
      if (ld) begin
        out.valid <= emit;
        out.data <= head[15:0];
        out.start <= emit & start;
        out.last <= emit & last;
        state <= state_n;
        wc <= wc_n;
      end else if (out.ready) out.valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_event_fifo_reader.sv
// tb_event_fifo_reader: directed self-checking bench for the event FIFO drain
module tb_event_fifo_reader;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic [17:0] fifo_q = '0;
  logic fifo_re, fifo_empty;
  logic [15:0] event_count;
  logic err_framing, err_overlength, busy;
  logic [17:0] mem [0:63];
  int pushed = 0;
  int popped = 0;
  int cyc = 0;
  int got_n = 0;
  int nf = 0;
  int no = 0;
  int bad_re = 0;
  int stab_err = 0;
  logic [17:0] got_w [0:63];
  int got_t [0:63];
  logic prev_stall = 1'b0;
  logic [17:0] prev_w = '0;
  int checks = 0;
  int errors = 0;
  int b, p0, nf0, no0, t_push, max_occ;
  logic [5:0] pat = 6'b101001;

  event_fifo_reader_if s();

  event_fifo_reader #(.g_max_event_words(4), .g_count_width(16)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .enable(enable),
    .fifo_empty(fifo_empty),
    .fifo_q(fifo_q),
    .fifo_re(fifo_re),
    .out(s),
    .event_count(event_count),
    .err_framing(err_framing),
    .err_overlength(err_overlength),
    .busy(busy)
  );

  always #5 clock = ~clock;

  assign fifo_empty = pushed == popped;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (fifo_re) begin
      fifo_q <= mem[popped];
      popped <= popped + 1;
    end
    if (fifo_re && fifo_empty) bad_re <= bad_re + 1;
    if (s.valid && s.ready) begin
      got_w[got_n] <= {s.start, s.last, s.data};
      got_t[got_n] <= cyc;
      got_n <= got_n + 1;
    end
    if (err_framing) nf <= nf + 1;
    if (err_overlength) no <= no + 1;
    if (!reset_n) prev_stall <= 1'b0;
    else begin
      if (prev_stall && (s.valid !== 1'b1 || {s.start, s.last, s.data} !== prev_w)) stab_err <= stab_err + 1;
      prev_stall <= s.valid & ~s.ready;
      prev_w <= {s.start, s.last, s.data};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [17:0] w);
    mem[pushed] = w;
    pushed++;
  endtask

  task automatic wait_got(input int n, input int maxc);
    for (int i = 0; i < maxc && got_n < n; i++) @(negedge clock);
  endtask

  initial begin
    s.ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_valid", s.valid, 0);
    chk("rst_count", event_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {s.start, s.last, err_framing, err_overlength, fifo_re}, 0);
    reset_n = 1'b1;
    @(negedge clock);

    enable = 1'b1;
    s.ready = 1'b1;
    b = got_n;
    t_push = cyc;
    push({2'b01, 16'h1111});
    push({2'b00, 16'h2222});
    push({2'b00, 16'h3333});
    push({2'b10, 16'h4444});
    wait_got(b + 4, 20);
    repeat (2) @(negedge clock);
    chk("t1_n", got_n - b, 4);
    chk("t1_w0", got_w[b], {2'b10, 16'h1111});
    chk("t1_w1", got_w[b + 1], {2'b00, 16'h2222});
    chk("t1_w2", got_w[b + 2], {2'b00, 16'h3333});
    chk("t1_w3", got_w[b + 3], {2'b01, 16'h4444});
    chk("t1_latency", got_t[b] - t_push, 2);
    chk("t1_back2back", got_t[b + 3] - got_t[b], 3);
    chk("t1_count", event_count, 1);
    chk("t1_errs", nf + no, 0);

    b = got_n;
    max_occ = 0;
    push({2'b01, 16'hA001});
    push({2'b00, 16'hA002});
    push({2'b00, 16'hA003});
    push({2'b10, 16'hA004});
    for (int i = 0; i < 60 && got_n < b + 4; i++) begin
      s.ready = pat[i % 6];
      @(negedge clock);
      if (popped - got_n > max_occ) max_occ = popped - got_n;
    end
    s.ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("t2_n", got_n - b, 4);
    chk("t2_w0", got_w[b], {2'b10, 16'hA001});
    chk("t2_w1", got_w[b + 1], {2'b00, 16'hA002});
    chk("t2_w2", got_w[b + 2], {2'b00, 16'hA003});
    chk("t2_w3", got_w[b + 3], {2'b01, 16'hA004});
    chk("t2_occ", max_occ <= 3, 1);
    chk("t2_stable", stab_err, 0);
    chk("t2_count", event_count, 2);

    b = got_n;
    nf0 = nf;
    push({2'b00, 16'hAAAA});
    push({2'b11, 16'hBBBB});
    wait_got(b + 1, 20);
    repeat (3) @(negedge clock);
    chk("t3_n", got_n - b, 1);
    chk("t3_w0", got_w[b], {2'b11, 16'hBBBB});
    chk("t3_framing", nf - nf0, 1);
    chk("t3_count", event_count, 3);

    b = got_n;
    nf0 = nf;
    no0 = no;
    push({2'b01, 16'hC001});
    push({2'b00, 16'hC002});
    push({2'b00, 16'hC003});
    push({2'b00, 16'hC004});
    push({2'b00, 16'hC005});
    push({2'b10, 16'hC006});
    push({2'b11, 16'hC007});
    wait_got(b + 5, 40);
    repeat (3) @(negedge clock);
    chk("t4_n", got_n - b, 5);
    chk("t4_w0", got_w[b], {2'b10, 16'hC001});
    chk("t4_w1", got_w[b + 1], {2'b00, 16'hC002});
    chk("t4_w2", got_w[b + 2], {2'b00, 16'hC003});
    chk("t4_w3", got_w[b + 3], {2'b01, 16'hC004});
    chk("t4_w4", got_w[b + 4], {2'b11, 16'hC007});
    chk("t4_overlength", no - no0, 1);
    chk("t4_framing", nf - nf0, 2);
    chk("t4_count", event_count, 5);

    b = got_n;
    p0 = popped;
    push({2'b01, 16'hD001});
    push({2'b00, 16'hD002});
    push({2'b00, 16'hD003});
    push({2'b10, 16'hD004});
    @(negedge clock);
    enable = 1'b0;
    repeat (8) @(negedge clock);
    chk("t5_reads", popped - p0, 1);
    chk("t5_n", got_n - b, 1);
    chk("t5_w0", got_w[b], {2'b10, 16'hD001});
    chk("t5_busy", busy, 1);
    enable = 1'b1;
    wait_got(b + 4, 30);
    repeat (2) @(negedge clock);
    chk("t5_reads_all", popped - p0, 4);
    chk("t5_w3", got_w[b + 3], {2'b01, 16'hD004});
    chk("t5_count", event_count, 6);

    s.ready = 1'b0;
    p0 = popped;
    push({2'b01, 16'hE001});
    push({2'b00, 16'hE002});
    push({2'b00, 16'hE003});
    repeat (6) @(negedge clock);
    chk("t6_reads", popped - p0, 3);
    chk("t6_held", {s.valid, s.data}, {1'b1, 16'hE001});
    reset_n = 1'b0;
    #1;
    chk("t6_rst_out", {s.valid, s.start, s.last, s.data}, 0);
    chk("t6_rst_misc", {busy, fifo_re, err_framing, err_overlength}, 0);
    chk("t6_rst_count", event_count, 0);
    @(negedge clock);
    reset_n = 1'b1;
    s.ready = 1'b1;
    b = got_n;
    nf0 = nf;
    push({2'b01, 16'hF001});
    push({2'b10, 16'hF002});
    wait_got(b + 2, 20);
    repeat (2) @(negedge clock);
    chk("t6_n", got_n - b, 2);
    chk("t6_w0", got_w[b], {2'b10, 16'hF001});
    chk("t6_w1", got_w[b + 1], {2'b01, 16'hF002});
    chk("t6_count", event_count, 1);
    chk("t6_framing", nf - nf0, 0);

    chk("fifo_re_on_empty", bad_re, 0);
    chk("stall_stable", stab_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
